// File: rtl/usb_pkg.sv
// Shared PID codes, transaction states and packet header for the USB host engine.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA_OUT, S_WAIT_HS, S_WAIT_DATA, S_SEND_ACK, S_RETRY, S_DONE
  } txn_state_e;

  typedef struct packed {
    logic [3:0] pid;
    logic       is_data;
    logic [6:0] addr;
    logic [3:0] endp;
  } pkt_hdr_t;

  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_retry_timer.sv
// Response timeout timer and retry counter for the transaction engine.
module usb_retry_timer #(
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_RETRY   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_timer,
  input  logic run,
  input  logic inc_retry,
  input  logic clr_retry,
  output logic timeout,
  output logic retry_exhausted
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  logic [TW-1:0] tmr;
  logic [RW-1:0] retry;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr   <= '0;
      retry <= '0;
    end else begin
      if (clr_timer)      tmr <= '0;
      else if (run)       tmr <= tmr + TW'(1);
      if (clr_retry)      retry <= '0;
      else if (inc_retry) retry <= retry + RW'(1);
    end
  end

  // Only a counting cycle can expire, so rx_busy also holds off the timeout itself.
  assign timeout         = run && (tmr == T_LAST);
  assign retry_exhausted = (retry == R_MAX);

endmodule

// File: rtl/usb_txn_engine.sv
// Host-side USB transaction engine: token -> data -> handshake with per-endpoint
// DATA0/DATA1 toggle tracking, response timeout and bounded retries.
module usb_txn_engine import usb_pkg::*; #(
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_RETRY   = 8,
  parameter int NUM_ENDP    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_in,
  input  logic [6:0]        req_addr,
  input  logic [3:0]        req_endp,
  input  logic [DATA_W-1:0] req_data,
  output logic              done_valid,
  output logic              done_cancel,
  output logic [DATA_W-1:0] done_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        tx_pid,
  output logic              tx_is_data,
  output logic [6:0]        tx_addr,
  output logic [3:0]        tx_endp,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_busy,
  input  logic              rx_valid,
  input  logic [3:0]        rx_pid,
  input  logic              rx_crc_err,
  input  logic [DATA_W-1:0] rx_data
);

  txn_state_e          state;
  pkt_hdr_t            hdr;
  logic                is_in, dup;
  logic [NUM_ENDP-1:0] toggle, endp_mask;
  logic                tog_cur, waiting, rx_ok, timeout, retry_exhausted;

  // Out-of-range endpoints get an all-zero mask: toggle reads as DATA0 and never flips.
  assign endp_mask = NUM_ENDP'(1) << hdr.endp;
  assign tog_cur   = |(toggle & endp_mask);
  assign waiting   = (state == S_WAIT_HS) || (state == S_WAIT_DATA);
  assign rx_ok     = rx_valid && !rx_crc_err;

  assign tx_pid     = hdr.pid;
  assign tx_is_data = hdr.is_data;
  assign tx_addr    = hdr.addr;
  assign tx_endp    = hdr.endp;

  usb_retry_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) u_timer (
    .clk             (clk),
    .rst             (rst),
    .clr_timer       (state == S_TOKEN),
    .run             (waiting && !rx_busy),
    .inc_retry       ((state == S_RETRY) && !retry_exhausted),
    .clr_retry       (state == S_IDLE),
    .timeout         (timeout),
    .retry_exhausted (retry_exhausted)
  );

  // Outputs are registered, so the cancel pulse is armed on the way into RETRY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      hdr         <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      done_valid  <= 1'b0;
      done_cancel <= 1'b0;
      done_data   <= '0;
      toggle      <= '0;
      is_in       <= 1'b0;
      dup         <= 1'b0;
    end else begin
      done_valid  <= 1'b0;
      done_cancel <= 1'b0;
      unique case (state)
        S_IDLE: if (req_valid) begin
          state     <= S_TOKEN;
          req_ready <= 1'b0;
          is_in     <= req_is_in;
          tx_valid  <= 1'b1;
          hdr       <= '{pid: req_is_in ? PID_IN : PID_OUT, is_data: 1'b0,
                         addr: req_addr, endp: req_endp};
          tx_data   <= req_data;
        end
        S_TOKEN: if (tx_ready) begin
          if (is_in) begin
            state    <= S_WAIT_DATA;
            tx_valid <= 1'b0;
          end else begin
            state       <= S_DATA_OUT;
            hdr.pid     <= tog_cur ? PID_DATA1 : PID_DATA0;
            hdr.is_data <= 1'b1;
          end
        end
        S_DATA_OUT: if (tx_ready) begin
          state    <= S_WAIT_HS;
          tx_valid <= 1'b0;
        end
        S_WAIT_HS: if (rx_ok && rx_pid == PID_ACK) begin
          toggle     <= toggle ^ endp_mask;
          state      <= S_DONE;
          done_valid <= 1'b1;
        end else if (rx_valid || timeout) begin
          state       <= S_RETRY;
          done_valid  <= retry_exhausted;
          done_cancel <= retry_exhausted;
        end
        S_WAIT_DATA: if (rx_ok && is_data_pid(rx_pid)) begin
          // A wrong-toggle packet is a replay of data we already took: ACK it, keep nothing.
          dup <= (rx_pid[3] != tog_cur);
          if (rx_pid[3] == tog_cur) begin
            done_data <= rx_data;
            toggle    <= toggle ^ endp_mask;
          end
          state       <= S_SEND_ACK;
          tx_valid    <= 1'b1;
          hdr.pid     <= PID_ACK;
          hdr.is_data <= 1'b0;
        end else if (rx_valid || timeout) begin
          state       <= S_RETRY;
          done_valid  <= retry_exhausted;
          done_cancel <= retry_exhausted;
        end
        S_SEND_ACK: if (tx_ready) begin
          tx_valid <= 1'b0;
          if (dup) begin
            state       <= S_RETRY;
            done_valid  <= retry_exhausted;
            done_cancel <= retry_exhausted;
          end else begin
            state      <= S_DONE;
            done_valid <= 1'b1;
          end
        end
        S_RETRY: if (retry_exhausted) begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end else begin
          state       <= S_TOKEN;
          tx_valid    <= 1'b1;
          hdr.pid     <= is_in ? PID_IN : PID_OUT;
          hdr.is_data <= 1'b0;
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_txn_engine.sv
// Bench for usb_txn_engine: table vectors, randomized transactions against a
// transaction-level device/toggle model, and directed timing/reset sequences.
module tb_usb_txn_engine;
  import usb_pkg::*;

  localparam int DATA_W = 64;
  localparam int TC     = 16;
  localparam int MR     = 8;
  localparam int NE     = 16;
  localparam int R_OK = 0, R_NAK = 1, R_CRC = 2, R_TO = 3, R_DUP = 4, R_BAD = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_ready, req_is_in = 1'b0;
  logic [6:0]        req_addr = '0;
  logic [3:0]        req_endp = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              done_valid, done_cancel;
  logic [DATA_W-1:0] done_data;
  logic              tx_valid, tx_ready = 1'b0, tx_is_data;
  logic [3:0]        tx_pid, tx_endp;
  logic [6:0]        tx_addr;
  logic [DATA_W-1:0] tx_data;
  logic              rx_busy = 1'b0, rx_valid = 1'b0, rx_crc_err = 1'b0;
  logic [3:0]        rx_pid = '0;
  logic [DATA_W-1:0] rx_data = '0;

  usb_txn_engine #(.DATA_W(DATA_W), .TIMEOUT_CYC(TC), .MAX_RETRY(MR), .NUM_ENDP(NE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_in(req_is_in),
    .req_addr(req_addr), .req_endp(req_endp), .req_data(req_data),
    .done_valid(done_valid), .done_cancel(done_cancel), .done_data(done_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pid(tx_pid), .tx_is_data(tx_is_data),
    .tx_addr(tx_addr), .tx_endp(tx_endp), .tx_data(tx_data),
    .rx_busy(rx_busy), .rx_valid(rx_valid), .rx_pid(rx_pid),
    .rx_crc_err(rx_crc_err), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit tog[NE];   // expected DATA0/DATA1 toggle per endpoint

  typedef struct {
    bit        is_in;
    bit [3:0]  endp;
    bit [63:0] data;
    int        r_first;
    int        n_first;
    int        r_then;
    int        exp_tokens;
    bit        exp_cancel;
    bit [3:0]  exp_dpid;
    bit [63:0] exp_ddata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < NE; i++) tog[i] = 1'b0;
  endtask

  task automatic send_req(input bit is_in, input bit [3:0] endp, input bit [6:0] addr,
                          input bit [63:0] data);
    int n = 0;
    while (!req_ready && n < 20) begin tick; n++; end
    chk("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_is_in = is_in; req_endp = endp; req_addr = addr; req_data = data;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic wait_tx(output bit ok);
    int n = 0;
    while (!tx_valid && n < 64) begin
      if (done_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_done: got done_valid=1 expected 0");
      end
      tick; n++;
    end
    chk("tx_valid_wait", 64'(tx_valid), 64'd1);
    ok = tx_valid;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done_valid && n < 20) begin tick; n++; end
    chk("done_valid", 64'(done_valid), 64'd1);
  endtask

  task automatic accept_tx;
    repeat ($urandom_range(0, 2)) tick;
    tx_ready = 1'b1;
    tick;
    tx_ready = 1'b0;
  endtask

  task automatic send_rx(input logic [3:0] pid, input bit crc, input logic [63:0] data);
    rx_valid = 1'b1; rx_pid = pid; rx_crc_err = crc; rx_data = data;
    tick;
    rx_valid = 1'b0; rx_crc_err = 1'b0;
  endtask

  // Plays the device side of one transaction. Attempts below n_first get r_first,
  // later ones r_then; outcome predicted from the toggle model.
  task automatic run_txn(input bit is_in, input bit [3:0] endp, input bit [6:0] addr,
                         input bit [63:0] data, input int r_first, input int n_first,
                         input int r_then, output int tokens, output bit cancel,
                         output bit [3:0] dpid, output bit [63:0] ddata);
    bit ok, fin, exp_ack, success;
    int r;
    logic [3:0] good_pid, bad_pid;
    tokens = 0; cancel = 0; dpid = 0; ddata = 0; fin = 0;
    send_req(is_in, endp, addr, data);
    for (int att = 0; att <= MR && !fin; att++) begin
      r = (att < n_first) ? r_first : r_then;
      wait_tx(ok);
      if (!ok) fin = 1;
      else begin
        chk("token_pid", 64'(tx_pid), is_in ? 64'(PID_IN) : 64'(PID_OUT));
        chk("token_dest", 64'({tx_endp, tx_addr}), 64'({endp, addr}));
        tokens++;
        accept_tx;
        good_pid = tog[endp] ? PID_DATA1 : PID_DATA0;
        bad_pid  = tog[endp] ? PID_DATA0 : PID_DATA1;
        if (!is_in) begin
          wait_tx(ok);
          if (att == 0) dpid = tx_pid;
          chk("data_pid", 64'(tx_pid), 64'(good_pid));
          chk("data_is_data", 64'(tx_is_data), 64'd1);
          chk("tx_data", tx_data, data);
          accept_tx;
        end
        repeat ($urandom_range(0, 3)) tick;
        exp_ack = is_in && (r == R_OK || r == R_DUP);
        success = (r == R_OK);
        case (r)
          R_OK:    if (is_in) send_rx(good_pid, 1'b0, data); else send_rx(PID_ACK, 1'b0, '0);
          R_DUP:   if (is_in) send_rx(bad_pid, 1'b0, ~data); else send_rx(PID_DATA0, 1'b0, '0);
          R_NAK:   send_rx(PID_NAK, 1'b0, '0);
          R_CRC:   send_rx(is_in ? good_pid : PID_ACK, 1'b1, ~data);
          R_BAD:   send_rx(PID_IN, 1'b0, '0);
          default: ;
        endcase
        if (exp_ack) begin
          wait_tx(ok);
          chk("ack_pid", 64'(tx_pid), 64'(PID_ACK));
          chk("ack_is_data", 64'(tx_is_data), 64'd0);
          accept_tx;
        end
        if (success) begin
          tog[endp] = !tog[endp];
          wait_done;
          chk("done_cancel_ok", 64'(done_cancel), 64'd0);
          if (is_in) chk("done_data", done_data, data);
          ddata = done_data;
          fin = 1;
        end else if (att == MR) begin
          wait_done;
          chk("done_cancel", 64'(done_cancel), 64'd1);
          cancel = done_cancel;
          fin = 1;
        end
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int tokens, n;
    bit cancel;
    bit [3:0] dpid;
    bit [63:0] ddata;

    tbl[0] = '{1'b0, 4'd3, 64'hAABBCCDD, R_OK,  0, R_OK, 1, 1'b0, PID_DATA0, 64'h0};
    tbl[1] = '{1'b0, 4'd3, 64'h11223344, R_OK,  0, R_OK, 1, 1'b0, PID_DATA1, 64'h0};
    tbl[2] = '{1'b1, 4'd1, 64'h1234,     R_OK,  0, R_OK, 1, 1'b0, 4'h0, 64'h1234};
    tbl[3] = '{1'b1, 4'd1, 64'h5678,     R_DUP, 1, R_OK, 2, 1'b0, 4'h0, 64'h5678};
    tbl[4] = '{1'b0, 4'd5, 64'h55,       R_NAK, 9, R_OK, 9, 1'b1, PID_DATA0, 64'h0};
    tbl[5] = '{1'b0, 4'd5, 64'h66,       R_OK,  0, R_OK, 1, 1'b0, PID_DATA0, 64'h0};
    tbl[6] = '{1'b1, 4'd9, 64'hCAFE,     R_CRC, 1, R_OK, 2, 1'b0, 4'h0, 64'hCAFE};
    tbl[7] = '{1'b1, 4'd9, 64'hBEEF,     R_BAD, 2, R_OK, 3, 1'b0, 4'h0, 64'hBEEF};
    tbl[8] = '{1'b0, 4'd9, 64'h77,       R_TO,  1, R_OK, 2, 1'b0, PID_DATA0, 64'h0};

    do_reset;
    chk("rst_req_ready",   64'(req_ready),   64'd1);
    chk("rst_tx_valid",    64'(tx_valid),    64'd0);
    chk("rst_done_valid",  64'(done_valid),  64'd0);
    chk("rst_done_cancel", 64'(done_cancel), 64'd0);
    chk("rst_tx_pid",      64'(tx_pid),      64'd0);
    chk("rst_done_data",   done_data,        64'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].is_in, tbl[i].endp, 7'h2A, tbl[i].data, tbl[i].r_first,
              tbl[i].n_first, tbl[i].r_then, tokens, cancel, dpid, ddata);
      chk($sformatf("vec%0d_tokens", i), 64'(tokens), 64'(tbl[i].exp_tokens));
      chk($sformatf("vec%0d_cancel", i), 64'(cancel), 64'(tbl[i].exp_cancel));
      if (!tbl[i].is_in) chk($sformatf("vec%0d_dpid", i), 64'(dpid), 64'(tbl[i].exp_dpid));
      else if (!tbl[i].exp_cancel) chk($sformatf("vec%0d_ddata", i), ddata, tbl[i].exp_ddata);
    end

    for (int i = 0; i < 30; i++) begin
      int rf, nf;
      rf = $urandom_range(1, 5);
      nf = ($urandom_range(0, 4) == 0) ? MR + 1 : $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, NE - 1)), 7'($urandom),
              {$urandom, $urandom}, rf, nf, R_OK, tokens, cancel, dpid, ddata);
      chk("rand_cancel", 64'(cancel), 64'(nf > MR));
    end

    // No response: 16 counting WAIT cycles, then one RETRY cycle before the token returns.
    send_req(1'b1, 4'd7, 7'h11, 64'h0);
    chk("to_token_pid", 64'(tx_pid), 64'(PID_IN));
    tx_ready = 1'b1; tick; tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 64) begin tick; n++; end
    chk("timeout_gap", 64'(n), 64'(TC + 1));
    tx_ready = 1'b1; tick; tx_ready = 1'b0;
    rx_busy = 1'b1; repeat (5) tick; rx_busy = 1'b0;
    n = 5;
    while (!tx_valid && n < 64) begin tick; n++; end
    chk("timeout_gap_busy", 64'(n), 64'(TC + 6));
    do_reset;

    run_txn(1'b0, 4'd3, 7'h03, 64'h99, R_OK, 0, R_OK, tokens, cancel, dpid, ddata);
    chk("pre_rst_dpid", 64'(dpid), 64'(PID_DATA0));

    // Downstream stall: token must hold still for 10 cycles.
    send_req(1'b0, 4'd2, 7'h5A, 64'hDEAD);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 64'(tx_valid), 64'd1);
      chk("stall_pid", 64'(tx_pid), 64'(PID_OUT));
      chk("stall_dest", 64'({tx_endp, tx_addr}), 64'({4'd2, 7'h5A}));
      tick;
    end
    tx_ready = 1'b1; tick; tx_ready = 1'b0;
    chk("stall_data_pid", 64'(tx_pid), 64'(PID_DATA0));
    tx_ready = 1'b1; tick; tx_ready = 1'b0;
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < NE; i++) tog[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 64'(done_valid), 64'd0);
      chk("abort_idle", 64'({req_ready, tx_valid}), 64'b10);
      tick;
    end

    // toggle[3] was 1 before reset; reset must bring it back to DATA0.
    run_txn(1'b0, 4'd3, 7'h03, 64'hAB, R_OK, 0, R_OK, tokens, cancel, dpid, ddata);
    chk("post_rst_dpid", 64'(dpid), 64'(PID_DATA0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
